ntt_cg_addrgen: RTL and testbench
=================================

Name: ntt_cg_addrgen

Overview:
- Parametrised constant-geometry NTT address generator for a radix-2 BFU. Drives four single-clock dual-port data RAMs arranged as two ping-pong bank pairs, plus a flat twiddle ROM.
- Supports any power-of-two N, a configurable BFU pipeline latency, forward/inverse twiddle selection, a stall input, and a start/busy/done handshake.
- Sits between the top-level controller and the RAM/ROM/BFU datapath.

Parameters:
- LOG_N, 8, log2 of transform size N. Legal range 3..12. Stages = LOG_N; butterflies per stage H = N/2.
- BFU_LAT, 4, cycles from a read issue to the matching write. Legal range 1..15.
- AW, LOG_N-1, RAM address width. Each RAM holds H words.
- RAW, clog2(LOG_N*N), twiddle ROM address width.

Ports:
- clk  in  1  Single clock.
- rst  in  1  Synchronous reset, active-high.
- start  in  1  Single-cycle request. Sampled only in IDLE.
- inv  in  1  Inverse-transform select. Latched on an accepted start.
- stall  in  1  Freezes all counters and the write delay line while high.
- busy  out  1  High from the cycle after an accepted start through the done cycle.
- done  out  1  One-cycle pulse at the end of the transform.
- stage  out  clog2(LOG_N)  Current stage index.
- bank_sel  out  1  0: read from RAM0/RAM1, write to RAM2/RAM3. 1: the reverse.
- rd_en  out  1  Read strobe. Applies to both RAMs of the read pair.
- rd_addr  out  AW  Butterfly index k. Same address on both read RAMs (x[k], x[k+H]).
- rom_en  out  1  Equals rd_en.
- rom_addr  out  RAW  Twiddle address.
- wr_en  out  1  Write strobe for the current write pair.
- wr_upper  out  1  0: lower RAM of the write pair. 1: upper RAM.
- wr_addr_a  out  AW  Port-A write address.
- wr_addr_b  out  AW  Port-B write address.
- ram_en  out  4  Per-RAM enable, one-hot decoded.
- ram_we  out  4  Per-RAM write enable, one-hot decoded.

Behaviour:
- All outputs are registered.
- On reset:
  - State = IDLE.
  - busy, done, rd_en, rom_en, wr_en = 0.
  - stage, bank_sel, rd_addr, rom_addr, wr_* = 0; ram_en = 0, ram_we = 0.
  - Delay line cleared.
- Reset mid-transform aborts immediately with no further writes.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 → RUN; latch inv; stage=0; bank_sel=0. start while busy is ignored.
  - RUN: issue one read per non-stalled cycle, k = 0..H-1. After k=H-1 → DRAIN.
  - DRAIN: wait until BFU_LAT non-stalled cycles have elapsed after the last read.
    - If stage < LOG_N-1: stage+1, bank_sel toggles, → RUN.
    - Else: done=1 for one cycle → IDLE. bank_sel holds the result bank (LOG_N odd → 1).
- Timing without stall, start accepted at cycle T:
  - Read k of stage s occurs at cycle T+1+s*(H+BFU_LAT)+k.
  - Its write occurs BFU_LAT cycles later.
  - The next stage's first read immediately follows the previous stage's last write.
  - done is asserted at T+LOG_N*(H+BFU_LAT)+1. busy deasserts the cycle after.
- Write addressing for butterfly k (writes y[2k], y[2k+1]):
  - 2k < H: wr_upper=0, wr_addr_a=2k, wr_addr_b=2k+1.
  - Otherwise: wr_upper=1, wr_addr_a=2k-H, wr_addr_b=2k-H+1.
- Delay line:
  - BFU_LAT-deep shift of {valid, k}.
  - Advances only when stall=0.
  - wr_en = valid at the tail AND !stall.
- Twiddle address: rom_addr = (inv ? LOG_N*H : 0) + stage*H + k. Computed at RAW width, no wrap.
- ram_en / ram_we decode:
  - Read pair: en only.
  - Write RAM: ram_en=1, ram_we=1, both ports.
  - Read and write to the same RAM never occur in the same cycle.
- Stall:
  - rd_en, rom_en, wr_en forced to 0; ram_en = ram_we = 0.
  - All counters hold.
  - Stall in IDLE has no effect.
  - start together with stall is still accepted; the first read is delayed until stall falls.

Decomposition:
- Package ntt_pkg holds:
  - State enum {IDLE, RUN, DRAIN}.
  - Default LOG_N and BFU_LAT.
  - clog2 function.
  - RAM index constants RAM0..RAM3.
- Sub-module ntt_wr_delay: parametrised stallable valid/index shift register of depth BFU_LAT.

Test Plan:
- LOG_N=4, BFU_LAT=2, start at cycle 10, no stall:
  - rd_addr steps 0..7 on cycles 11..18.
  - Writes on cycles 13..20 with addresses (0,1),(2,3),(4,5),(6,7) lower, then (0,1)…(6,7) upper.
  - done at cycle 10+4*10+1=51; final bank_sel=0.
- LOG_N=8, BFU_LAT=4, inv=1:
  - First rom_addr=1024; stage 3 k=5 gives rom_addr=1024+384+5=1413.
  - done 1057 cycles after start.
- Stall held 3 cycles at stage 1, k=20:
  - rd_en, wr_en, ram_en = 0 during the stall.
  - Address sequence resumes at k=21 with no loss or duplication.
  - done delayed by exactly 3 cycles.
- start pulsed while busy:
  - Ignored; transform and done timing unchanged.
- rst asserted in stage 2, RUN:
  - Next cycle all outputs 0, state IDLE, no wr_en.
  - A new start then runs normally from stage 0.
- Scoreboard, LOG_N=5:
  - Read and write RAM are never the same in any cycle.
  - Each write pair covers every address 0..H-1 exactly once per stage.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared state type, default parameters, RAM indices and clog2 helper
// for the constant-geometry NTT address generator.
package ntt_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    localparam int LOG_N_DEF = 8;
    localparam int BFU_LAT_DEF = 4;
    localparam int RAM0 = 0;
    localparam int RAM1 = 1;
    localparam int RAM2 = 2;
    localparam int RAM3 = 3;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ntt_cg_addrgen_if.sv
// ntt_cg_addrgen_if: controller-side handshake plus RAM/ROM address bus of the
// NTT address generator; master is the controller, slave is the generator.
interface ntt_cg_addrgen_if #(parameter int LOG_N = ntt_pkg::LOG_N_DEF);
    import ntt_pkg::*;
    localparam int AW = LOG_N - 1;
    localparam int RAW = clog2(LOG_N << LOG_N);
    localparam int SW = clog2(LOG_N);
    logic start, inv, stall, busy, done, bank_sel, rd_en, rom_en, wr_en, wr_upper;
    logic [SW-1:0] stage;
    logic [AW-1:0] rd_addr, wr_addr_a, wr_addr_b;
    logic [RAW-1:0] rom_addr;
    logic [3:0] ram_en, ram_we;
    modport master (
        output start, inv, stall,
        input busy, done, stage, bank_sel, rd_en, rd_addr, rom_en, rom_addr,
        input wr_en, wr_upper, wr_addr_a, wr_addr_b, ram_en, ram_we
    );
    modport slave (
        input start, inv, stall,
        output busy, done, stage, bank_sel, rd_en, rd_addr, rom_en, rom_addr,
        output wr_en, wr_upper, wr_addr_a, wr_addr_b, ram_en, ram_we
    );
endinterface

// File: rtl/ntt_wr_delay.sv
// ntt_wr_delay: stallable shift register carrying {valid, butterfly index}
// from read issue to write, DEPTH advances long.
module ntt_wr_delay #(
    parameter int DEPTH = 4,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv_i,
    input  logic         v_i,
    input  logic [W-1:0] k_i,
    output logic         v_o,
    output logic [W-1:0] k_o
);
    logic [DEPTH-1:0] v_q;
    logic [W-1:0] k_q [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) k_q[i] <= '0;
        end else if (adv_i) begin
            v_q[0] <= v_i;
            k_q[0] <= k_i;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                k_q[i] <= k_q[i-1];
            end
        end
    end
    assign v_o = v_q[DEPTH-1];
    assign k_o = k_q[DEPTH-1];
endmodule

// File: rtl/ntt_cg_addrgen.sv
// ntt_cg_addrgen: constant-geometry radix-2 NTT sequencer driving ping-pong
// RAM pairs, the twiddle ROM and the BFU write-back addresses.
module ntt_cg_addrgen
    import ntt_pkg::*;
#(
    parameter int LOG_N = LOG_N_DEF,
    parameter int BFU_LAT = BFU_LAT_DEF
) (
    input logic clk,
    input logic rst,
    ntt_cg_addrgen_if.slave io
);
    localparam int H = 1 << (LOG_N - 1);
    localparam int AW = LOG_N - 1;
    localparam int RAW = clog2(LOG_N << LOG_N);
    localparam int SW = clog2(LOG_N);
    localparam int CW = clog2(BFU_LAT + 1);

    state_e st_q, st_d;
    logic [AW-1:0] k_q, k_d, rd_k, tail_k;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stage_q, stage_d;
    logic bank_q, bank_d, inv_q, inv_d, go, issue, done_d, tail_v, wr_go;
    logic [RAW-1:0] rom_d;
    logic [3:0] en_d, we_d;

    ntt_wr_delay #(.DEPTH(BFU_LAT), .W(AW)) u_dly (
        .clk(clk), .rst(rst), .adv_i(go), .v_i(issue), .k_i(rd_k), .v_o(tail_v), .k_o(tail_k)
    );

    // The edge that leaves IDLE or DRAIN already issues read 0 of the new stage.
    always_comb begin
        st_d = st_q;
        k_d = k_q;
        cnt_d = cnt_q;
        stage_d = stage_q;
        bank_d = bank_q;
        inv_d = inv_q;
        done_d = 1'b0;
        go = !io.stall;
        case (st_q)
            IDLE: if (io.start) begin
                st_d = RUN;
                inv_d = io.inv;
                stage_d = '0;
                bank_d = 1'b0;
                k_d = '0;
            end
            DRAIN: if (go) begin
                if (cnt_q != CW'(BFU_LAT)) cnt_d = cnt_q + CW'(1);
                else begin
                    bank_d = !bank_q;
                    k_d = '0;
                    st_d = stage_q == SW'(LOG_N - 1) ? IDLE : RUN;
                    done_d = stage_q == SW'(LOG_N - 1);
                    stage_d = done_d ? stage_q : stage_q + SW'(1);
                end
            end
            default: ;
        endcase
        rd_k = k_d;
        issue = go && (st_q == RUN || st_d == RUN);
        if (issue) begin
            k_d = rd_k + AW'(1);
            if (rd_k == AW'(H - 1)) begin
                st_d = DRAIN;
                cnt_d = '0;
            end
        end
        rom_d = (inv_d ? RAW'(LOG_N * H) : RAW'(0)) + (RAW'(stage_d) << AW) + RAW'(rd_k);
        wr_go = tail_v && go;
        we_d = wr_go ? 4'(1) << ((bank_d ? RAM0 : RAM2) + int'(tail_k[AW-1])) : 4'(0);
        en_d = we_d | (issue ? (4'(1) << (bank_d ? RAM2 : RAM0)) | (4'(1) << (bank_d ? RAM3 : RAM1)) : 4'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= IDLE;
            k_q <= '0;
            cnt_q <= '0;
            stage_q <= '0;
            bank_q <= 1'b0;
            inv_q <= 1'b0;
            io.busy <= 1'b0;
            io.done <= 1'b0;
            io.rd_en <= 1'b0;
            io.rom_en <= 1'b0;
            io.rd_addr <= '0;
            io.rom_addr <= '0;
            io.wr_en <= 1'b0;
            io.wr_upper <= 1'b0;
            io.wr_addr_a <= '0;
            io.wr_addr_b <= '0;
            io.ram_en <= '0;
            io.ram_we <= '0;
        end else begin
            st_q <= st_d;
            k_q <= k_d;
            cnt_q <= cnt_d;
            stage_q <= stage_d;
            bank_q <= bank_d;
            inv_q <= inv_d;
            io.busy <= st_d != IDLE || done_d;
            io.done <= done_d;
            io.rd_en <= issue;
            io.rom_en <= issue;
            io.wr_en <= wr_go;
            io.ram_en <= en_d;
            io.ram_we <= we_d;
            if (issue) begin
                io.rd_addr <= rd_k;
                io.rom_addr <= rom_d;
            end
            // Butterfly k writes y[2k], y[2k+1]; the top bit of k picks the upper RAM.
            if (wr_go) begin
                io.wr_upper <= tail_k[AW-1];
                io.wr_addr_a <= {tail_k[AW-2:0], 1'b0};
                io.wr_addr_b <= {tail_k[AW-2:0], 1'b1};
            end
        end
    end

    assign io.stage = stage_q;
    assign io.bank_sel = bank_q;
endmodule

// File: tb/tb_ntt_cg_addrgen.sv
// tb_ntt_cg_addrgen: randomized scoreboard bench; expected reads, writes, done and
// busy come from a slot-count schedule model and are checked by a separate monitor.
module tb_ntt_cg_addrgen;
    import ntt_pkg::*;
    localparam int LOG_N = 5;
    localparam int BFU_LAT = 3;
    localparam int H = 1 << (LOG_N - 1);
    localparam int P = H + BFU_LAT;

    typedef struct {int cyc; int stage; int bank; int k; int rom;} rd_t;
    typedef struct {int cyc; int bank; int upper; int a; int b;} wr_t;
    typedef struct {int cyc; int v;} ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_cg_addrgen_if #(.LOG_N(LOG_N)) io();
    ntt_cg_addrgen #(.LOG_N(LOG_N), .BFU_LAT(BFU_LAT)) dut (.clk(clk), .rst(rst), .io(io.slave));

    rd_t rdq[$];
    wr_t wrq[$];
    ev_t bq[$];
    ev_t dq[$];
    int zq[$];
    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    bit busy_m = 0;
    bit inv_m = 0;
    int j = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, ncyc, act, exp);
        end
    endtask

    // Model: after an accepted start every non-stalled edge is one schedule slot;
    // slot j belongs to stage j/P, reads at offsets 0..H-1, writes BFU_LAT later.
    task automatic tick(input bit r, input bit s, input bit iv, input bit sl);
        bit done_now;
        int st, off, k;
        rst = r;
        io.start = s;
        io.inv = iv;
        io.stall = sl;
        @(posedge clk);
        #1;
        done_now = 0;
        if (r) begin
            busy_m = 0;
            zq.push_back(ncyc);
        end else begin
            if (!busy_m && s) begin
                busy_m = 1;
                j = 0;
                inv_m = iv;
            end
            if (busy_m && !sl) begin
                if (j == LOG_N * P) begin
                    dq.push_back('{ncyc, 1});
                    busy_m = 0;
                    done_now = 1;
                end else begin
                    st = j / P;
                    off = j % P;
                    if (off < H)
                        rdq.push_back('{ncyc, st, st % 2, off, (inv_m ? LOG_N * H : 0) + st * H + off});
                    if (off >= BFU_LAT) begin
                        k = off - BFU_LAT;
                        wrq.push_back('{ncyc, st % 2, int'(2 * k >= H), (2 * k) % H, (2 * k) % H + 1});
                    end
                end
                j++;
            end
        end
        bq.push_back('{ncyc, int'(busy_m || done_now)});
    endtask

    always @(negedge clk) begin
        if (bq.size() != 0 && bq[0].cyc == ncyc) begin
            ev_t e;
            rd_t rr;
            wr_t ww;
            bit er, ew, ed;
            logic [3:0] een, ewe;
            e = bq.pop_front();
            chk("busy", io.busy, e.v);
            er = rdq.size() != 0 && rdq[0].cyc == ncyc;
            ew = wrq.size() != 0 && wrq[0].cyc == ncyc;
            ed = dq.size() != 0 && dq[0].cyc == ncyc;
            een = '0;
            ewe = '0;
            chk("rd_en", io.rd_en, er);
            chk("rom_en", io.rom_en, er);
            if (er) begin
                rr = rdq.pop_front();
                chk("rd_addr", io.rd_addr, rr.k);
                chk("rom_addr", io.rom_addr, rr.rom);
                chk("rd_stage", io.stage, rr.stage);
                chk("rd_bank", io.bank_sel, rr.bank);
                een = rr.bank != 0 ? 4'b1100 : 4'b0011;
            end
            chk("wr_en", io.wr_en, ew);
            if (ew) begin
                ww = wrq.pop_front();
                chk("wr_upper", io.wr_upper, ww.upper);
                chk("wr_addr_a", io.wr_addr_a, ww.a);
                chk("wr_addr_b", io.wr_addr_b, ww.b);
                ewe = 4'b0001 << ((ww.bank != 0 ? 0 : 2) + ww.upper);
            end
            chk("done", io.done, ed);
            if (ed) begin
                e = dq.pop_front();
                chk("done_stage", io.stage, LOG_N - 1);
                chk("done_bank", io.bank_sel, LOG_N % 2);
            end
            chk("ram_we", io.ram_we, ewe);
            chk("ram_en", io.ram_en, een | ewe);
            if (zq.size() != 0 && zq[0] == ncyc) begin
                void'(zq.pop_front());
                chk("reset_outputs", {io.busy, io.done, io.stage, io.bank_sel, io.rd_en, io.rd_addr,
                    io.rom_en, io.rom_addr, io.wr_en, io.wr_upper, io.wr_addr_a, io.wr_addr_b,
                    io.ram_en, io.ram_we}, 0);
            end
        end
    end

    initial begin
        repeat (3) tick(1, 0, 0, 0);
        repeat (4) tick(0, 0, 1'($urandom % 2), 1'($urandom % 2));
        for (int t = 0; t < 8; t++) begin
            int budget, abort_at;
            bit quiet;
            quiet = t == 0;
            budget = 0;
            abort_at = t == 3 ? 2 * P + int'($urandom_range(0, H - 1)) : -1;
            tick(0, 1, 1'($urandom % 2), !quiet && $urandom % 4 == 0);
            while (busy_m && budget < 2000) begin
                budget++;
                if (j == abort_at) begin
                    tick(1, 0, 0, 0);
                    abort_at = -1;
                end else
                    tick(0, !quiet && $urandom % 16 == 0, 1'($urandom % 2), !quiet && $urandom % 8 == 0);
            end
            chk("transform_budget", budget < 2000, 1);
            repeat ($urandom_range(1, 4)) tick(0, 0, 0, 1'($urandom % 2));
        end
        repeat (2) tick(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("rd_left", rdq.size(), 0);
        chk("wr_left", wrq.size(), 0);
        chk("done_left", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
